adder_share_arbiter: RTL and testbench

Shares one combinational `ripple_carry_adder` (WIDTH-bit operands, WIDTH+1-bit sum) among NREQ requesters. It arbitrates round-robin, muxes the winner's operands into the adder, registers the sum with the winner's ID, and holds the result under valid/ready backpressure. It sits between multiple arithmetic clients and the single shared adder datapath.

---
 rtl/adder_share_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//
// Shares a single combinational ripple-carry adder among NREQ requesters.
// A round-robin arbiter picks one requester per cycle. Its operands are muxed
// into the adder, and the WIDTH+1-bit sum is registered together with the
// winner's index. The registered result is held under valid/ready
// backpressure.
//
// Optional feature macro: ADDER_ARB_STATS_EN
//   When defined, adds o_carry_cnt. This is a saturating 16-bit count of
//   registered results whose carry bit (o_sum[WIDTH]) is set.
//
// Ports
//   clk         in   1            rising-edge clock
//   rst_n       in   1            synchronous active-low reset
//   i_req       in   NREQ         per-requester request level
//   i_a         in   NREQ*WIDTH   operand A, requester k at [k*WIDTH +: WIDTH]
//   i_b         in   NREQ*WIDTH   operand B, same packing
//   o_gnt       out  NREQ         one-hot acceptance pulse (combinational)
//   o_valid     out  1            result valid
//   o_id        out  IDW          index of requester owning o_sum
//   o_sum       out  WIDTH+1      registered a+b, carry in MSB
//   i_ready     in   1            consumer accepts result when valid && ready
//   o_carry_cnt out  16           (ADDER_ARB_STATS_EN only) carry result count
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter  int WIDTH = 10,
  parameter  int NREQ  = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_a,
  input  logic [NREQ*WIDTH-1:0] i_b,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_valid,
  output logic [IDW-1:0]        o_id,
  output logic [WIDTH:0]        o_sum,
  input  logic                  i_ready
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0]           o_carry_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  // Unsigned ripple-carry adder with no carry-in. The final carry lands in
  // the MSB, so the result never overflows.
  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    logic           c;
    s = {(WIDTH+1){1'b0}};
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    s[WIDTH] = c;
    return s;
  endfunction

  state_t             state_r;
  logic [IDW-1:0]     ptr_r;
  logic [IDW-1:0]     id_r;
  logic [WIDTH:0]     sum_r;
`ifdef ADDER_ARB_STATS_EN
  logic [15:0]        carry_cnt_r;
`endif

  logic               valid_s;
  logic               can_accept_s;
  logic               found_hi_s;
  logic               found_lo_s;
  logic [IDW-1:0]     win_hi_s;
  logic [IDW-1:0]     win_lo_s;
  logic               found_s;
  logic [IDW-1:0]     win_s;
  logic               grant_v_s;
  logic [NREQ-1:0]    gnt_s;
  logic [WIDTH-1:0]   a_sel_s;
  logic [WIDTH-1:0]   b_sel_s;
  logic [WIDTH:0]     sum_s;
  logic [IDW-1:0]     ptr_next_s;

  assign valid_s      = (state_r == ST_FULL);
  assign can_accept_s = !valid_s || i_ready;

  // Round-robin pick. The lowest requester at or above ptr wins. If there is
  // none, the lowest requester overall wins, which implements the wrap to 0.
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    win_hi_s   = {IDW{1'b0}};
    win_lo_s   = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (i_req[k] && !found_hi_s && (IDW'(k) >= ptr_r)) begin
        found_hi_s = 1'b1;
        win_hi_s   = IDW'(k);
      end else begin
        found_hi_s = found_hi_s;
      end
      if (i_req[k] && !found_lo_s) begin
        found_lo_s = 1'b1;
        win_lo_s   = IDW'(k);
      end else begin
        found_lo_s = found_lo_s;
      end
    end
    if (found_hi_s) begin
      win_s = win_hi_s;
    end else begin
      win_s = win_lo_s;
    end
    found_s = found_hi_s | found_lo_s;
  end

  // Grant qualification. No grant is issued while reset is asserted.
  always_comb begin
    grant_v_s = rst_n && found_s && can_accept_s;
    gnt_s     = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (grant_v_s && (win_s == IDW'(k))) begin
        gnt_s[k] = 1'b1;
      end else begin
        gnt_s[k] = 1'b0;
      end
    end
  end

  // Operand mux that feeds the winner's operands into the shared adder.
  always_comb begin
    a_sel_s = {WIDTH{1'b0}};
    b_sel_s = {WIDTH{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (win_s == IDW'(k)) begin
        a_sel_s = i_a[k*WIDTH +: WIDTH];
        b_sel_s = i_b[k*WIDTH +: WIDTH];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
  end

  // Shared adder and the pointer advance past the winner.
  always_comb begin
    sum_s = ripple_add(a_sel_s, b_sel_s);
    if (win_s == LAST_IDX) begin
      ptr_next_s = {IDW{1'b0}};
    end else begin
      ptr_next_s = win_s + IDW'(1);
    end
  end

  // Result FSM: EMPTY/FULL, plus result, ID, pointer and optional stats regs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      sum_r       <= {(WIDTH+1){1'b0}};
      id_r        <= {IDW{1'b0}};
      ptr_r       <= {IDW{1'b0}};
`ifdef ADDER_ARB_STATS_EN
      carry_cnt_r <= 16'h0000;
`endif
    end else if (grant_v_s) begin
      // Accept new operands. Covers EMPTY->FULL and accept-and-replace.
      state_r     <= ST_FULL;
      sum_r       <= sum_s;
      id_r        <= win_s;
      ptr_r       <= ptr_next_s;
`ifdef ADDER_ARB_STATS_EN
      if (sum_s[WIDTH] && (carry_cnt_r != 16'hFFFF)) begin
        carry_cnt_r <= carry_cnt_r + 16'h0001;
      end else begin
        carry_cnt_r <= carry_cnt_r;
      end
`endif
    end else begin
      case (state_r)
        ST_FULL: begin
          if (i_ready) begin
            state_r <= ST_EMPTY;
          end else begin
            state_r <= ST_FULL;
          end
        end
        ST_EMPTY: begin
          state_r <= ST_EMPTY;
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  assign o_gnt   = gnt_s;
  assign o_valid = valid_s;
  assign o_id    = id_r;
  assign o_sum   = sum_r;
`ifdef ADDER_ARB_STATS_EN
  assign o_carry_cnt = carry_cnt_r;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
//
// Directed bench for adder_share_arbiter. It keeps a reference model built
// from the arbitration and result rules (round-robin search, 1-cycle result
// latency, valid/ready hold). The model is checked on every falling edge, and
// hand-computed literal expectations are checked at fixed points.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

  localparam int WIDTH = 10;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_a;
  logic [NREQ*WIDTH-1:0] i_b;
  logic [NREQ-1:0]       o_gnt;
  logic                  o_valid;
  logic [IDW-1:0]        o_id;
  logic [WIDTH:0]        o_sum;
  logic                  i_ready;
`ifdef ADDER_ARB_STATS_EN
  logic [15:0]           o_carry_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  int op_a [NREQ];
  int op_b [NREQ];

  // Reference model state.
  int m_ptr   = 0;
  int m_id    = 0;
  int m_sum   = 0;
  int m_cnt   = 0;
  bit m_valid = 1'b0;

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_gnt   (o_gnt),
    .o_valid (o_valid),
    .o_id    (o_id),
    .o_sum   (o_sum),
    .i_ready (i_ready)
`ifdef ADDER_ARB_STATS_EN
    ,
    .o_carry_cnt (o_carry_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting index found scanning upward from ptr with wraparound, or -1.
  function automatic int pick(input int req, input int ptr);
    for (int d = 0; d < NREQ; d++) begin
      if (((req >> ((ptr + d) % NREQ)) & 1) != 0) return (ptr + d) % NREQ;
    end
    return -1;
  endfunction

  // Model update at each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    int w;
    w = pick(int'(i_req), m_ptr);
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sum   <= 0;
      m_id    <= 0;
      m_ptr   <= 0;
      m_cnt   <= 0;
    end else if ((!m_valid || i_ready) && w >= 0) begin
      m_valid <= 1'b1;
      m_sum   <= op_a[w] + op_b[w];
      m_id    <= w;
      m_ptr   <= (w + 1) % NREQ;
      if ((op_a[w] + op_b[w]) >= (1 << WIDTH) && m_cnt < 65535) m_cnt <= m_cnt + 1;
    end else if (m_valid && i_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle compare of the DUT against the model, on the falling edge.
  always @(negedge clk) begin
    int w;
    int eg;
    w  = pick(int'(i_req), m_ptr);
    eg = (rst_n && (!m_valid || i_ready) && w >= 0) ? (1 << w) : 0;
    check("cmp_gnt",   32'(o_gnt),   32'(eg));
    check("cmp_valid", 32'(o_valid), 32'(m_valid));
    check("cmp_id",    32'(o_id),    32'(m_id));
    check("cmp_sum",   32'(o_sum),   32'(m_sum));
`ifdef ADDER_ARB_STATS_EN
    check("cmp_cnt",   32'(o_carry_cnt), 32'(m_cnt));
`endif
  end

  task automatic set_op(input int k, input int a, input int b);
    op_a[k] = a;
    op_b[k] = b;
    i_a[k*WIDTH +: WIDTH] = WIDTH'(a);
    i_b[k*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Advance to just after the next rising edge, then drive the control inputs.
  task automatic step(input logic rst, input logic [NREQ-1:0] req, input logic rdy);
    @(posedge clk);
    #1;
    rst_n   = rst;
    i_req   = req;
    i_ready = rdy;
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_req   = 4'b0000;
    i_ready = 1'b1;
    i_a     = '0;
    i_b     = '0;
    for (int k = 0; k < NREQ; k++) set_op(k, 100 * k + 1, k + 2);

    // Reset with all requesters active.
    step(1'b0, 4'b1111, 1'b1);
    check("rst_gnt", 32'(o_gnt), 32'h0);
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    check("rst_gnt2",  32'(o_gnt),   32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_sum",   32'(o_sum),   32'h0);
    check("rst_id",    32'(o_id),    32'h0);

    // Round-robin across all four requesters.
    step(1'b1, 4'b1111, 1'b1);
    check("rr_g0", 32'(o_gnt), 32'h1);
    step(1'b1, 4'b1111, 1'b1);
    check("rr_g1", 32'(o_gnt), 32'h2);
    check("rr_id0", 32'(o_id), 32'd0);
    check("rr_sum0", 32'(o_sum), 32'd3);
    step(1'b1, 4'b1111, 1'b1);
    check("rr_g2", 32'(o_gnt), 32'h4);
    check("rr_sum1", 32'(o_sum), 32'd104);
    step(1'b1, 4'b1111, 1'b1);
    check("rr_g3", 32'(o_gnt), 32'h8);
    check("rr_sum2", 32'(o_sum), 32'd205);
    step(1'b1, 4'b1111, 1'b1);
    check("rr_g0b", 32'(o_gnt), 32'h1);
    check("rr_sum3", 32'(o_sum), 32'd306);
    step(1'b1, 4'b1001, 1'b1);
    check("rr_1001_a", 32'(o_gnt), 32'h8);
    step(1'b1, 4'b1001, 1'b1);
    check("rr_1001_b", 32'(o_gnt), 32'h1);
    check("rr_id3", 32'(o_id), 32'd3);
    step(1'b1, 4'b0000, 1'b1);
    check("drain_valid", 32'(o_valid), 32'h1);
    step(1'b1, 4'b0000, 1'b1);
    check("empty_valid", 32'(o_valid), 32'h0);
    check("empty_sum_hold", 32'(o_sum), 32'd3);

    // Single requester, back-to-back operations every cycle.
    step(1'b1, 4'b0010, 1'b1);
    set_op(1, 300, 500);
    check("one_gnt", 32'(o_gnt), 32'h2);
    step(1'b1, 4'b0010, 1'b1);
    set_op(1, 1023, 1023);
    check("one_gnt2", 32'(o_gnt), 32'h2);
    check("one_valid", 32'(o_valid), 32'h1);
    check("one_id", 32'(o_id), 32'd1);
    check("one_sum", 32'(o_sum), 32'd800);
    step(1'b1, 4'b0010, 1'b1);
    set_op(1, 0, 0);
    check("carry_sum", 32'(o_sum), 32'h7FE);
    step(1'b1, 4'b0000, 1'b1);
    check("zero_sum", 32'(o_sum), 32'h0);
    check("zero_valid", 32'(o_valid), 32'h1);

    // Backpressure with requester 2 pending.
    step(1'b1, 4'b0100, 1'b1);
    set_op(2, 7, 9);
    check("bp_gnt0", 32'(o_gnt), 32'h4);
    step(1'b1, 4'b0100, 1'b0);
    set_op(2, 200, 1000);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step(1'b1, 4'b0100, 1'b0);
      check("bp_gnt_hold", 32'(o_gnt), 32'h0);
      check("bp_id_hold",  32'(o_id),  32'd2);
      check("bp_sum_hold", 32'(o_sum), 32'd16);
    end
    step(1'b1, 4'b0100, 1'b1);
    check("bp_release_gnt", 32'(o_gnt), 32'h4);
    step(1'b1, 4'b0000, 1'b1);
    check("bp_new_sum", 32'(o_sum), 32'd1200);

    // Reset while holding a result from requester 3.
    step(1'b1, 4'b1000, 1'b1);
    set_op(3, 1023, 1);
    check("mr_gnt", 32'(o_gnt), 32'h8);
    step(1'b1, 4'b0000, 1'b0);
    check("mr_full_id", 32'(o_id), 32'd3);
    check("mr_full_sum", 32'(o_sum), 32'h400);
    step(1'b0, 4'b1000, 1'b0);
    check("mr_rst_gnt", 32'(o_gnt), 32'h0);
    step(1'b1, 4'b1111, 1'b1);
    check("mr_valid", 32'(o_valid), 32'h0);
    check("mr_ptr0", 32'(o_gnt), 32'h1);

    // Three carry-producing adds.
    step(1'b1, 4'b1000, 1'b1);
    step(1'b1, 4'b1000, 1'b1);
    step(1'b1, 4'b1000, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
`ifdef ADDER_ARB_STATS_EN
    check("stats_cnt3", 32'(o_carry_cnt), 32'd3);
`endif
    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
`ifdef ADDER_ARB_STATS_EN
    check("stats_cnt_rst", 32'(o_carry_cnt), 32'd0);
`endif
    check("final_valid", 32'(o_valid), 32'h0);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
